// File: rtl/jsoc_cpu_oci_dct_packer_if.sv
// Trace-symbol in / DCT-word out bundle for the OCI DCT packer.
// master = the packer, slave = the trace source plus consumer side.
interface jsoc_cpu_oci_dct_packer_if #(
  parameter int SYM_W = 2,
  parameter int DEPTH = 15,
  parameter int CNT_W = 4
);
  logic                   sym_valid;
  logic [SYM_W-1:0]       sym_data;
  logic                   sym_ready;
  logic                   flush;
  logic                   end_test;
  logic [SYM_W*DEPTH-1:0] dct_buffer;
  logic [CNT_W-1:0]       dct_count;
  logic                   dct_valid;
  logic                   dct_ready;
  logic                   test_ending;
  logic                   test_has_ended;

  modport master (
    input  sym_valid, sym_data, flush, end_test, dct_ready,
    output sym_ready, dct_buffer, dct_count, dct_valid, test_ending, test_has_ended
  );

  modport slave (
    output sym_valid, sym_data, flush, end_test, dct_ready,
    input  sym_ready, dct_buffer, dct_count, dct_valid, test_ending, test_has_ended
  );
endinterface

// File: rtl/jsoc_cpu_oci_dct_packer.sv
// Packs 2-bit trace symbols into 15-symbol DCT words behind a one-deep output
// slot, and sequences the end-of-test flush/drain.
module jsoc_cpu_oci_dct_packer #(
  parameter int SYM_W = 2,
  parameter int DEPTH = 15,
  parameter int CNT_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  jsoc_cpu_oci_dct_packer_if.master  bus
);

  localparam logic [1:0]       RUN   = 2'd0;
  localparam logic [1:0]       DRAIN = 2'd1;
  localparam logic [1:0]       DONE  = 2'd2;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  logic [1:0]                  state;
  logic [DEPTH-1:0][SYM_W-1:0] acc;
  logic [CNT_W-1:0]            acc_cnt;
  logic                        flush_pend;
  logic [DEPTH-1:0][SYM_W-1:0] out_buf;
  logic [CNT_W-1:0]            out_cnt;
  logic                        out_vld;

  logic sym_rdy, sym_take, slot_free, handoff, set_pend;

  // Acceptance stops while a flush is pending so the flushed word is exactly
  // what had arrived before the flush.
  assign sym_rdy   = !reset && (state == RUN) && (acc_cnt != FULL) && !flush_pend;
  assign sym_take  = bus.sym_valid && sym_rdy;
  assign slot_free = !out_vld || bus.dct_ready;
  assign handoff   = ((acc_cnt == FULL) || (flush_pend && (acc_cnt != '0))) && slot_free;
  // end_test subsumes a coincident flush: both simply request the partial word.
  assign set_pend  = (bus.end_test && (state == RUN)) || (bus.flush && (state != DONE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      acc        <= '0;
      acc_cnt    <= '0;
      flush_pend <= 1'b0;
      out_buf    <= '0;
      out_cnt    <= '0;
      out_vld    <= 1'b0;
    end else begin
      if (handoff) begin
        acc     <= '0;
        acc_cnt <= '0;
      end else if (sym_take) begin
        acc[acc_cnt] <= bus.sym_data;
        acc_cnt      <= acc_cnt + 1'b1;
      end

      // An empty flush is dropped once it has been seen with nothing to emit.
      if (set_pend)
        flush_pend <= 1'b1;
      else if (handoff || (flush_pend && (acc_cnt == '0)))
        flush_pend <= 1'b0;

      if (handoff) begin
        out_buf <= acc;
        out_cnt <= acc_cnt;
        out_vld <= 1'b1;
      end else if (bus.dct_ready) begin
        out_vld <= 1'b0;
      end

      case (state)
        RUN:     if (bus.end_test) state <= DRAIN;
        DRAIN:   if ((acc_cnt == '0) && !flush_pend && !out_vld) state <= DONE;
        DONE:    state <= DONE;
        default: state <= RUN;
      endcase
    end
  end

  // Outputs are forced low for the whole reset cycle, not just after the edge.
  assign bus.sym_ready      = sym_rdy;
  assign bus.dct_valid      = !reset && out_vld;
  assign bus.dct_buffer     = reset ? '0 : out_buf;
  assign bus.dct_count      = reset ? '0 : out_cnt;
  assign bus.test_ending    = !reset && (state != RUN);
  assign bus.test_has_ended = !reset && (state == DONE);

endmodule
